cpu_data_mem: RTL and testbench
===============================

# cpu_data_mem

Data-memory stage for the 16-bit pipelined CPU. It sits directly downstream of the CPU's MEM stage, takes `d_addr`/`d_dataout`/`d_we` and returns `d_datain`. It also clears itself after reset and signals when it is ready. A host load/dump port with a req/ack handshake lets benches preload operands and read back results without forcing internal arrays.

## Interface
- `ADDR_W`, 8: word-address width; depth = 2^ADDR_W.
- `DATA_W`, 16: word width.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset; 0 = skip the clear.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `d_addr` input ADDR_W: CPU word address.
- `d_dataout` input DATA_W: CPU store data.
- `d_we` input 1: CPU store strobe, sampled on the rising edge.
- `d_datain` output DATA_W: CPU load data.
- `mem_ready` output 1: high once the clear has finished. The bench/top holds CPU `start` until this is high.
- `host_req` input 1: host transaction request; held high until `host_ack`.
- `host_we` input 1: 1 = write, 0 = read; stable while `host_req` is high.
- `host_addr` input ADDR_W: host address; stable while `host_req` is high.
- `host_wdata` input DATA_W: host write data; stable while `host_req` is high.
- `host_ack` output 1: one-cycle completion pulse.
- `host_rdata` output DATA_W: registered read data; valid in the `host_ack` cycle and held until the next read completes.

## Operation
- Storage: 2^ADDR_W × DATA_W array.
- FSM states:
  - CLEAR: a counter `clr_idx` runs from 0 to depth-1, writing 0 to one word per cycle.
  - RUN: normal operation.
  - HACK: one cycle, drives `host_ack`, then returns to RUN.
- Transitions:
  - reset → CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR → RUN on the cycle that writes word depth-1.
  - RUN → HACK when a host transaction is accepted.
  - HACK → RUN unconditionally.
- CPU load: `d_datain` = mem[d_addr], combinational, so the MEM stage gets data in the same cycle.
- CPU store: mem[d_addr] <= d_dataout on the edge when `d_we` is high, in RUN or HACK.
- CPU stores during CLEAR are dropped. `d_datain` reads 0 during CLEAR (for clear-done words) or stale contents (for words not yet cleared); the CPU must not be started before `mem_ready`.
- Host accept: in RUN, with `host_req` high, the transaction is accepted unless `host_we` and `d_we` are both high that cycle.
  - A host write that collides with a CPU store is deferred. The CPU always has priority.
  - A host read is never deferred by CPU activity.
- Host write: mem[host_addr] <= host_wdata on the accept edge.
- Host read: `host_rdata` <= mem[host_addr] on the accept edge. This is read-before-write: a CPU store to the same address on the same edge is not visible.
- Requests during CLEAR or HACK wait. A `host_req` still high in the HACK cycle is not treated as a new request; a new request is accepted no earlier than the cycle after `host_ack`.
- Same-cycle CPU store and load to the same address: `d_datain` shows the old value; the new value appears the next cycle.

## Timing
- Reset values:
  - `mem_ready` 0 (1 if CLEAR_ON_RESET=0).
  - `host_ack` 0.
  - `host_rdata` 0.
  - `clr_idx` 0.
  - State CLEAR/RUN as above.
- Reset asserted mid-clear or mid-transaction:
  - `clr_idx` restarts at 0.
  - Any pending host transaction is abandoned; no ack is issued.
  - Words not yet cleared keep their old contents until the new clear reaches them.
- `mem_ready` rises in the first cycle after reset deassertion + 2^ADDR_W cycles. With the default 256 words, it is high in cycle 257 after reset falls.
- Host latency:
  - Uncontended: accept edge, then `host_ack` high in the next cycle (1 cycle).
  - Contended write: +1 cycle per colliding CPU store.
- `host_ack` is exactly one cycle wide.
- `d_datain` has zero cycles of latency: it is combinational from `d_addr` and the array.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`/`DATA_W` defaults (matching the CPU's 8-bit `d_addr` and 16-bit data) and the FSM state enum (CLEAR, RUN, HACK).
- One natural sub-module: `dmem_array`, holding the storage. It has two write ports, selected by a priority mux in the parent, plus one async read port and one sync read port.
- FSM, clear counter and arbitration live in `cpu_data_mem`.

## Test plan
- Reset with defaults → `mem_ready` 0 for 256 cycles and 1 in cycle 257; a sweep over all 256 `d_addr` values returns 0x0000.
- CPU store at `d_addr`=0x05, `d_dataout`=0x1234, `d_we`=1 → the next cycle, `d_addr`=0x05 gives `d_datain`=0x1234; in the store cycle itself it gives the old 0x0000.
- Host write 0x10=0xBEEF → `host_ack` one cycle later; host read of 0x10 → `host_rdata`=0xBEEF on ack; CPU load of 0x10 → 0xBEEF.
- Host write 0x20=0xAAAA in the same cycle as CPU store 0x20=0x5555 → ack delayed by 1 cycle; final mem[0x20]=0xAAAA.
- Reset reasserted at `clr_idx`=100 → `clr_idx` returns to 0; `mem_ready` rises 256 cycles after the second reset release.
- `d_we`=1 to 0x03 and `host_req` high during CLEAR → mem[0x03]=0 after clear; host ack occurs only after `mem_ready`.

Source files
------------

// File: rtl/cpu_data_mem_pkg.sv
// Shared CPU definitions: default data-memory geometry and the
// data-memory controller state encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;   // matches the CPU's 8-bit d_addr
  localparam int DATA_W = 16;  // CPU word width

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,  // zeroing the array, one word per cycle
    ST_RUN   = 2'd1,  // normal CPU + host service
    ST_HACK  = 2'd2   // single host_ack cycle
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Data-memory storage: two write ports, an async read port for the CPU
// load path and a registered read port for host reads.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr_s,
  output logic [DATA_W-1:0] rdata_s
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  // Array writes; the parent never enables both ports on conflicting data.
  always_ff @(posedge clock) begin
    if (we0) mem[addr0] <= wdata0;
    if (we1) mem[addr1] <= wdata1;
  end

  assign rdata_a = mem[raddr_a];

  // Registered read samples the pre-edge contents (read-before-write).
  always_ff @(posedge clock) begin
    if (reset)      rdata_s <= '0;
    else if (rd_en) rdata_s <= mem[raddr_s];
  end

endmodule

// File: rtl/cpu_data_mem.sv
// CPU data-memory stage: post-reset clear, combinational CPU load,
// CPU stores, and a req/ack host port that yields to CPU stores.
module cpu_data_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = cpu_pkg::ADDR_W,
  parameter int DATA_W         = cpu_pkg::DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              mem_ready,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata
);

  state_e            state;
  logic [ADDR_W-1:0] clr_idx;
  logic              cpu_wr, clr_wr, host_accept, host_wr, host_rd;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;

  // CPU stores are dropped while clearing; a host write loses to any CPU store.
  assign cpu_wr      = !reset && d_we && (state != ST_CLEAR);
  assign clr_wr      = !reset && (state == ST_CLEAR);
  assign host_accept = !reset && (state == ST_RUN) && host_req && !(host_we && d_we);
  assign host_wr     = host_accept && host_we;
  assign host_rd     = host_accept && !host_we;

  // Second write port is shared by the clear sweep and host writes.
  assign p1_we    = clr_wr || host_wr;
  assign p1_addr  = clr_wr ? clr_idx : host_addr;
  assign p1_wdata = clr_wr ? '0 : host_wdata;

  assign mem_ready = (state != ST_CLEAR);
  assign host_ack  = (state == ST_HACK);

  // Controller FSM and clear counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= ST_RUN;
        end
        ST_RUN:  if (host_accept) state <= ST_HACK;
        ST_HACK: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we0     (cpu_wr),
    .addr0   (d_addr),
    .wdata0  (d_dataout),
    .we1     (p1_we),
    .addr1   (p1_addr),
    .wdata1  (p1_wdata),
    .raddr_a (d_addr),
    .rdata_a (d_datain),
    .rd_en   (host_rd),
    .raddr_s (host_addr),
    .rdata_s (host_rdata)
  );

endmodule

// File: tb/tb_cpu_data_mem.sv
// Directed bench for cpu_data_mem; host responses go through a scoreboard
// queue checked by an independent monitor on the falling edge.
module tb_cpu_data_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_dataout = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_datain;
  logic        mem_ready;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  cpu_data_mem dut (
    .clock      (clock),
    .reset      (reset),
    .d_addr     (d_addr),
    .d_dataout  (d_dataout),
    .d_we       (d_we),
    .d_datain   (d_datain),
    .mem_ready  (mem_ready),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every ack must match the oldest expected host response.
  logic prev_ack = 1'b0;
  always @(negedge clock) begin
    if (host_ack === 1'b1) begin
      chk("ack_width", {31'd0, prev_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_read) chk("host_rdata", {16'd0, host_rdata}, {16'd0, e.data});
      end
    end
    prev_ack <= (host_ack === 1'b1);
  end

  task automatic host_start(input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rd);
    exp_t e;
    e.is_read = !we;
    e.data    = exp_rd;
    exp_q.push_back(e);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  task automatic host_wait(input int start_lat, input int limit, input int exp_lat,
                           input string name);
    int lat;
    lat = start_lat;
    while (host_ack !== 1'b1 && lat < limit) begin
      step();
      lat++;
    end
    chk(name, lat, exp_lat);
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic cpu_load(input logic [7:0] addr, input logic [15:0] exp, input string name);
    d_addr = addr;
    #1;
    chk(name, {16'd0, d_datain}, {16'd0, exp});
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (mem_ready !== 1'b1 && n < 400) begin
      chk({name, "_low"}, {31'd0, mem_ready}, 32'd0);
      step();
      n++;
    end
    chk(name, n, 256);
  endtask

  initial begin
    int lat;
    // Reset state
    reset = 1'b1;
    step(); step();
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    chk("rst_clr_idx", {24'd0, dut.clr_idx}, 32'd0);
    reset = 1'b0;
    wait_ready("ready_after_reset");

    // Cleared array
    for (int a = 0; a < 256; a++) cpu_load(8'(a), 16'h0000, "sweep_zero");

    // CPU store: old value in store cycle, new value next cycle
    d_addr = 8'h05; d_dataout = 16'h1234; d_we = 1'b1;
    #1 chk("store_same_cycle", {16'd0, d_datain}, 32'h0000);
    step();
    d_we = 1'b0;
    cpu_load(8'h05, 16'h1234, "store_next_cycle");
    d_addr = 8'h03; d_dataout = 16'h00FF; d_we = 1'b1;
    step();
    d_we = 1'b0;
    cpu_load(8'h03, 16'h00FF, "store_03");

    // Host write then read
    host_start(1'b1, 8'h10, 16'hBEEF, 16'h0);
    host_wait(0, 10, 1, "hwr_lat");
    step();
    host_start(1'b0, 8'h10, 16'h0, 16'hBEEF);
    host_wait(0, 10, 1, "hrd_lat");
    step();
    cpu_load(8'h10, 16'hBEEF, "cpu_sees_host_wr");
    host_start(1'b0, 8'h05, 16'h0, 16'h1234);
    host_wait(0, 10, 1, "hrd05_lat");
    step();

    // Contended host write: CPU wins first, host lands one cycle later
    d_addr = 8'h20; d_dataout = 16'h5555; d_we = 1'b1;
    host_start(1'b1, 8'h20, 16'hAAAA, 16'h0);
    step();
    d_we = 1'b0;
    host_wait(1, 10, 2, "contend_lat");
    step();
    cpu_load(8'h20, 16'hAAAA, "contend_final");
    host_start(1'b0, 8'h20, 16'h0, 16'hAAAA);
    host_wait(0, 10, 1, "contend_rd_lat");
    step();

    // Host read with same-edge CPU store: read-before-write
    d_addr = 8'h05; d_dataout = 16'h7777; d_we = 1'b1;
    host_start(1'b0, 8'h05, 16'h0, 16'h1234);
    step();
    d_we = 1'b0;
    host_wait(1, 10, 1, "rbw_lat");
    cpu_load(8'h05, 16'h7777, "rbw_cpu_new");
    step();

    // Request under reset is abandoned (monitor flags any ack)
    reset = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    step();
    host_req = 1'b0;
    reset = 1'b0;
    repeat (100) step();
    chk("clr_idx_100", {24'd0, dut.clr_idx}, 32'd100);
    reset = 1'b1;
    step();
    chk("clr_idx_restart", {24'd0, dut.clr_idx}, 32'd0);
    chk("ready_low_rereset", {31'd0, mem_ready}, 32'd0);
    reset = 1'b0;
    wait_ready("ready_after_rereset");

    // CPU store and host read during clear
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_addr = 8'h03; d_dataout = 16'hDEAD; d_we = 1'b1;
    host_start(1'b0, 8'h03, 16'h0, 16'h0000);
    lat = 0;
    repeat (10) begin step(); lat++; end
    d_we = 1'b0;
    host_wait(lat, 400, 257, "clear_host_lat");
    chk("ready_at_clear_ack", {31'd0, mem_ready}, 32'd1);
    cpu_load(8'h03, 16'h0000, "clear_drops_store");
    step(); step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
